// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
// Legality limits are common to the transmit and receive sides.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;

  localparam int MIN_CLKS_PER_BIT = 2;
  localparam int MIN_DATA_BITS    = 5;
  localparam int MAX_DATA_BITS    = 9;
  localparam int MIN_STOP_BITS    = 1;
  localparam int MAX_STOP_BITS    = 2;

endpackage

// File: rtl/uart_tx_if.sv
// Start/ready handshake between a word producer and the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx_done;

  modport master (output tx_start, output tx_data, input tx_ready, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_ready, output tx_done);
endinterface

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 1..CLKS_PER_BIT while enabled, pulses bit_done on
// the terminal count and reloads to 1 on the following edge.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic clear,
  output logic bit_done
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  TC    = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= ONE;
    end else if (enable) begin
      count <= (count == TC) ? ONE : count + ONE;
    end
  end

  assign bit_done = enable && (count == TC);

endmodule

// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, data LSB first, optional even parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert the even parity bit between data and stop.
module uart_tx_block
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic      clk,
  input  logic      n_rst,
  uart_tx_if.slave  tx_if,
  output logic      serial_out
);

  // state  | meaning
  // IDLE   | line high, tx_ready=1, waiting for tx_start
  // START  | driving the start bit (0)
  // DATA   | shifting payload out LSB first
  // PARITY | driving the even parity bit (UART_TX_PARITY_EN builds only)
  // STOP   | driving STOP_BITS stop bits (1)

  localparam int               IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;
  logic                 tx_ready_q;
  logic                 tx_done_q;
  logic                 bit_done;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .enable   (state != IDLE),
    .clear    (state == IDLE),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      serial_out <= LINE_IDLE;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
      shift_reg  <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_if.tx_start) begin
            shift_reg  <= tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_if.tx_data;
`endif
            serial_out <= 1'b0;
            tx_ready_q <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_done) begin
            serial_out <= shift_reg[0];
            shift_reg  <= shift_reg >> 1;
            bit_idx    <= '0;
            state      <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              serial_out <= parity_bit;
              state      <= PARITY;
`else
              serial_out <= LINE_IDLE;
              stop_cnt   <= 1'b0;
              state      <= STOP;
`endif
            end else begin
              serial_out <= shift_reg[0];
              shift_reg  <= shift_reg >> 1;
              bit_idx    <= bit_idx + IDX_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            serial_out <= LINE_IDLE;
            stop_cnt   <= 1'b0;
            state      <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            if (stop_cnt == LAST_STOP) begin
              tx_done_q  <= 1'b1;
              tx_ready_q <= 1'b1;
              state      <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          serial_out <= LINE_IDLE;
          tx_ready_q <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign tx_if.tx_ready = tx_ready_q;
  assign tx_if.tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_block.sv
// Self-checking bench for uart_tx_block: a frame-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_tx_block;

  localparam int CPB   = 10;
  localparam int DBITS = 8;
  localparam int SBITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME = (1 + DBITS + PBITS + SBITS) * CPB;

  logic tb_clk = 1'b0;
  logic n_rst;
  logic serial_out;

  uart_tx_if #(.DATA_BITS(DBITS)) tx_if ();

  uart_tx_block #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DBITS),
    .STOP_BITS    (SBITS)
  ) dut (
    .clk        (tb_clk),
    .n_rst      (n_rst),
    .tx_if      (tx_if.slave),
    .serial_out (serial_out)
  );

  always #5 tb_clk = ~tb_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of line levels, one per clock cycle.
  logic             m_out   = 1'b1;
  logic             m_ready = 1'b1;
  logic             m_done  = 1'b0;
  bit               m_busy  = 1'b0;
  bit               m_q[$];
  logic [DBITS-1:0] m_data;

  always begin
    @(posedge tb_clk);
    if (n_rst !== 1'b1) begin
      m_q.delete();
      m_busy  = 1'b0;
      m_out   = 1'b1;
      m_ready = 1'b1;
      m_done  = 1'b0;
    end else if (!m_busy) begin
      m_done = 1'b0;
      m_out  = 1'b1;
      if (tx_if.tx_start === 1'b1) begin
        m_data = tx_if.tx_data;
        repeat (CPB) m_q.push_back(1'b0);
        for (int i = 0; i < DBITS; i++) repeat (CPB) m_q.push_back(m_data[i]);
`ifdef UART_TX_PARITY_EN
        repeat (CPB) m_q.push_back(^m_data);
`endif
        repeat (SBITS * CPB) m_q.push_back(1'b1);
        m_busy  = 1'b1;
        m_ready = 1'b0;
        m_out   = m_q.pop_front();
      end
    end else if (m_q.size() > 0) begin
      m_out = m_q.pop_front();
    end else begin
      m_busy  = 1'b0;
      m_out   = 1'b1;
      m_ready = 1'b1;
      m_done  = 1'b1;
    end
    #1;
    check("model serial_out", serial_out, m_out);
    check("model tx_ready", tx_if.tx_ready, m_ready);
    check("model tx_done", tx_if.tx_done, m_done);
  end

  task automatic wait_idle();
    int budget;
    budget = 4 * FRAME;
    while (tx_if.tx_ready !== 1'b1 && budget > 0) begin
      @(posedge tb_clk); #1;
      budget--;
    end
    check("idle wait", tx_if.tx_ready, 1'b1);
    @(posedge tb_clk); #1;
  endtask

  // Sends one frame; optionally pokes tx_start with 0xFF at cycle 40.
  task automatic run_frame(input logic [DBITS-1:0] data, input bit poke,
                           output logic [DBITS-1:0] got, output int dones, output int done_at);
    @(negedge tb_clk);
    tx_if.tx_data  = data;
    tx_if.tx_start = 1'b1;
    @(posedge tb_clk); #1;
    tx_if.tx_start = 1'b0;
    got     = '0;
    dones   = 0;
    done_at = -1;
    for (int k = 1; k <= FRAME + 10; k++) begin
      if (k >= CPB + CPB / 2 && k < (DBITS + 1) * CPB && (k % CPB) == CPB / 2)
        got[(k - CPB - CPB / 2) / CPB] = serial_out;
      if (tx_if.tx_done === 1'b1) begin
        dones++;
        done_at = k;
      end
      if (poke && k == 40) begin
        tx_if.tx_start = 1'b1;
        tx_if.tx_data  = 8'hFF;
      end
      if (poke && k == 41) tx_if.tx_start = 1'b0;
      @(posedge tb_clk); #1;
    end
  endtask

  logic [DBITS-1:0] got;
  logic [DBITS-1:0] got2 [2];
  int               dones;
  int               done_at;
  int               idle_cnt;
  logic             exp_a5 [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    n_rst          = 1'b0;
    tx_if.tx_start = 1'b1;
    tx_if.tx_data  = 8'hFF;

    // Reset with tx_start held high
    repeat (2) begin
      @(posedge tb_clk); #1;
      check("reset serial_out", serial_out, 1'b1);
      check("reset tx_ready", tx_if.tx_ready, 1'b1);
      check("reset tx_done", tx_if.tx_done, 1'b0);
    end
    @(negedge tb_clk);
    tx_if.tx_start = 1'b0;
    n_rst          = 1'b1;
    @(posedge tb_clk); #1;
    check("post-reset idle", serial_out, 1'b1);

    // 0xA5 frame, mid-bit samples and handshake timing
    @(negedge tb_clk);
    tx_if.tx_data  = 8'hA5;
    tx_if.tx_start = 1'b1;
    @(posedge tb_clk); #1;
    tx_if.tx_start = 1'b0;
    for (int k = 1; k <= FRAME + 1; k++) begin
      if (k <= CPB) check("a5 start bit", serial_out, 1'b0);
      if ((k % CPB) == CPB / 2 && k / CPB < 9) check("a5 mid bit", serial_out, exp_a5[k / CPB]);
      if (k == FRAME - CPB / 2) check("a5 stop bit", serial_out, 1'b1);
      check("a5 tx_done", tx_if.tx_done, (k == FRAME + 1));
      check("a5 tx_ready", tx_if.tx_ready, (k == FRAME + 1));
      if (k <= FRAME) begin
        @(posedge tb_clk); #1;
      end
    end

    // Busy start request is ignored
    wait_idle();
    run_frame(8'h3C, 1'b1, got, dones, done_at);
    check("busy data", got, 8'h3C);
    check("busy done count", dones, 1);
    check("busy done cycle", done_at, FRAME + 1);

    // Back-to-back frames with tx_start held
    wait_idle();
    @(negedge tb_clk);
    tx_if.tx_data  = 8'h01;
    tx_if.tx_start = 1'b1;
    @(posedge tb_clk); #1;
    tx_if.tx_data = 8'h80;
    got2[0]  = '0;
    got2[1]  = '0;
    dones    = 0;
    idle_cnt = 0;
    for (int k = 1; k <= 2 * FRAME + 5; k++) begin
      int b;
      int j;
      b = (k <= FRAME + 1) ? 0 : FRAME + 1;
      j = k - b;
      if (j >= CPB + CPB / 2 && j < (DBITS + 1) * CPB && (j % CPB) == CPB / 2)
        got2[b == 0 ? 0 : 1][(j - CPB - CPB / 2) / CPB] = serial_out;
      if (tx_if.tx_done === 1'b1) dones++;
      if (k >= 2 && k <= FRAME + 2 && tx_if.tx_ready === 1'b1) idle_cnt++;
      if (k == FRAME) check("b2b last stop", serial_out, 1'b1);
      if (k == FRAME + 1) begin
        check("b2b gap high", serial_out, 1'b1);
        check("b2b gap done", tx_if.tx_done, 1'b1);
      end
      if (k == FRAME + 2) begin
        check("b2b second start", serial_out, 1'b0);
        check("b2b second busy", tx_if.tx_ready, 1'b0);
        tx_if.tx_start = 1'b0;
      end
      @(posedge tb_clk); #1;
    end
    check("b2b first data", got2[0], 8'h01);
    check("b2b second data", got2[1], 8'h80);
    check("b2b idle cycles", idle_cnt, 1);
    check("b2b done count", dones, 2);

    // Reset mid-frame at cycle 35
    wait_idle();
    @(negedge tb_clk);
    tx_if.tx_data  = 8'hC3;
    tx_if.tx_start = 1'b1;
    @(posedge tb_clk); #1;
    tx_if.tx_start = 1'b0;
    for (int k = 1; k < 35; k++) begin
      @(posedge tb_clk); #1;
    end
    n_rst = 1'b0;
    @(posedge tb_clk); #1;
    check("abort serial_out", serial_out, 1'b1);
    check("abort tx_ready", tx_if.tx_ready, 1'b1);
    check("abort tx_done", tx_if.tx_done, 1'b0);
    @(negedge tb_clk);
    n_rst = 1'b1;
    dones = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(posedge tb_clk); #1;
      if (tx_if.tx_done === 1'b1) dones++;
    end
    check("abort no done", dones, 0);
    run_frame(8'h55, 1'b0, got, dones, done_at);
    check("after abort data", got, 8'h55);
    check("after abort done count", dones, 1);

`ifdef UART_TX_PARITY_EN
    // Parity build: 0x07 has odd weight, so the even parity bit is 1
    wait_idle();
    @(negedge tb_clk);
    tx_if.tx_data  = 8'h07;
    tx_if.tx_start = 1'b1;
    @(posedge tb_clk); #1;
    tx_if.tx_start = 1'b0;
    for (int k = 1; k <= 111; k++) begin
      if (k == 85) check("par bit7", serial_out, 1'b0);
      if (k >= 91 && k <= 100) check("par parity bit", serial_out, 1'b1);
      if (k >= 101 && k <= 110) check("par stop bit", serial_out, 1'b1);
      check("par tx_done", tx_if.tx_done, (k == 111));
      @(posedge tb_clk); #1;
    end
`endif

    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
